// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - HI/LO multiply/divide sequencer, one bit per cycle
// Shift-add multiply and restoring divide on magnitudes; FIX applies the signs.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   output logic             Busy,
   output logic             Stall,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivZero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [2*WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]       opnd_q;
   logic                   div_q, qneg_q, rneg_q, divz_q;
   logic [WIDTH-1:0]       hi_q, lo_q;

   logic                   is_mdu, op_signed;
   logic [WIDTH-1:0]       rs_abs, rt_abs;
   logic [WIDTH:0]         mul_sum;
   logic [2*WIDTH:0]       div_sh;
   logic                   div_ge;
   logic [WIDTH-1:0]       div_diff;
   logic [2*WIDTH-1:0]     step_d, prod_fix;
   logic [WIDTH-1:0]       quo_fix, rem_fix;

   always_comb begin
      is_mdu = 1'b0;
      case (Funct)
         F_MFHI, F_MTHI, F_MFLO, F_MTLO,
         F_MULT, F_MULTU, F_DIV, F_DIVU: is_mdu = 1'b1;
         default:                        is_mdu = 1'b0;
      endcase
   end

   // MULT and DIV are the even codes of their pairs
   assign op_signed = (Funct == F_MULT) || (Funct == F_DIV);
   assign rs_abs    = (op_signed && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
   assign rt_abs    = (op_signed && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   // Divide: acc = {remainder, dividend/quotient}, shifted left.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = {acc_q, 1'b0};
      div_ge   = div_sh[2*WIDTH:WIDTH] >= {1'b0, opnd_q};
      div_diff = div_sh[2*WIDTH-1:WIDTH] - opnd_q;
      step_d   = acc_q;
      if (state_q == MUL)
         step_d = {mul_sum, acc_q[WIDTH-1:1]};
      else if (div_ge)
         step_d = {div_diff, div_sh[WIDTH-1:1], 1'b1};
      else
         step_d = div_sh[2*WIDTH-1:0];
      prod_fix = qneg_q ? -acc_q : acc_q;
      quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         div_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         divz_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         divz_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  case (Funct)
                     F_MTHI: hi_q <= Rdata1;
                     F_MTLO: lo_q <= Rdata1;
                     F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (Funct[1] && (Rdata2 == '0)) begin
                           divz_q <= 1'b1;
                        end else begin
                           acc_q   <= {{WIDTH{1'b0}}, rs_abs};
                           opnd_q  <= rt_abs;
                           qneg_q  <= op_signed && (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                           rneg_q  <= op_signed && Rdata1[WIDTH-1];
                           div_q   <= Funct[1];
                           cnt_q   <= '0;
                           state_q <= Funct[1] ? DIV : MUL;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            MUL, DIV: begin
               acc_q <= step_d;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FIX: begin
               if (div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy    = (state_q != IDLE);
   assign Stall   = Busy && Start && is_mdu;
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivZero = divz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;

   localparam int W = 32;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         Start = 1'b0;
   logic [5:0]   Funct = '0;
   logic [W-1:0] Rdata1 = '0;
   logic [W-1:0] Rdata2 = '0;
   logic         Busy, Stall, DivZero;
   logic [W-1:0] HI, LO;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   mdu_seq #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
      .Rdata1(Rdata1), .Rdata2(Rdata2), .Busy(Busy), .Stall(Stall),
      .HI(HI), .LO(LO), .DivZero(DivZero)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a single accepting edge; returns at the negedge after it.
   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge CLK);
      Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
      @(negedge CLK);
      Start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (Busy && n < 100) begin
         n++;
         @(negedge CLK);
      end
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (Stall && n < 100) begin
         n++;
         @(negedge CLK);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1 RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_busy", Busy, 0);
      check("rst_stall", Stall, 0);
      check("rst_hi", HI, 0);
      check("rst_lo", LO, 0);
      check("rst_divz", DivZero, 0);
      RST = 1'b0;

      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu_busy_e0", Busy, 1);
      check("multu_hi_hold", HI, 0);
      wait_idle(cyc);
      check("multu_busy_cycles", cyc, 33);
      check("multu_hi", HI, 32'hFFFFFFFE);
      check("multu_lo", LO, 32'h00000001);

      issue(F_MULT, 32'hFFFFFFFD, 32'd7);
      wait_idle(cyc);
      check("mult_hi", HI, 32'hFFFFFFFF);
      check("mult_lo", LO, 32'hFFFFFFEB);

      issue(F_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(cyc);
      check("div_neg_lo", LO, 32'hFFFFFFFD);
      check("div_neg_hi", HI, 32'hFFFFFFFF);

      issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(cyc);
      check("div_ovf_lo", LO, 32'h80000000);
      check("div_ovf_hi", HI, 32'h0);

      issue(F_MTHI, 32'h12345678, 32'h0);
      check("mthi_busy", Busy, 0);
      check("mthi_hi", HI, 32'h12345678);
      issue(F_MTLO, 32'h12345678, 32'h0);
      check("mtlo_lo", LO, 32'h12345678);
      issue(F_DIVU, 32'd100, 32'd0);
      check("divz_pulse", DivZero, 1);
      check("divz_busy", Busy, 0);
      @(negedge CLK);
      check("divz_clear", DivZero, 0);
      check("divz_hi", HI, 32'h12345678);
      check("divz_lo", LO, 32'h12345678);

      issue(F_MULT, 32'd6, 32'd7);
      check("mul67_divz", DivZero, 0);
      repeat (5) @(negedge CLK);
      Start = 1'b1; Funct = F_MFLO; Rdata1 = '0; Rdata2 = '0;
      #1;
      check("mflo_stall_on", Stall, 1);
      wait_stall(cyc);
      check("mflo_stall_cycles", cyc, 28);
      check("mflo_busy", Busy, 0);
      check("mflo_lo", LO, 32'd42);
      check("mflo_hi", HI, 32'd0);
      @(negedge CLK);
      Start = 1'b0;

      issue(F_DIVU, 32'd1000, 32'd7);
      Start = 1'b1; Funct = F_MTHI; Rdata1 = 32'hDEADBEEF; Rdata2 = '0;
      #1;
      check("mthi_stall_on", Stall, 1);
      check("mthi_hi_held", HI, 32'd0);
      wait_stall(cyc);
      check("mthi_stall_cycles", cyc, 33);
      check("divu_hi", HI, 32'd6);
      check("divu_lo", LO, 32'd142);
      @(negedge CLK);
      Start = 1'b0;
      check("mthi_applied", HI, 32'hDEADBEEF);
      check("mthi_lo_kept", LO, 32'd142);

      issue(F_MULTU, 32'd5, 32'd7);
      repeat (9) @(negedge CLK);
      Start = 1'b1; Funct = F_MTHI; Rdata1 = 32'h1; Rdata2 = '0;
      #1;
      check("pre_rst_stall", Stall, 1);
      #1 RST = 1'b1;
      #1;
      check("arst_busy", Busy, 0);
      check("arst_stall", Stall, 0);
      check("arst_hi", HI, 0);
      check("arst_lo", LO, 0);
      check("arst_divz", DivZero, 0);
      Start = 1'b0;
      @(negedge CLK);
      RST = 1'b0;

      issue(F_MULTU, 32'd2, 32'd3);
      wait_idle(cyc);
      check("post_rst_cycles", cyc, 33);
      check("post_rst_lo", LO, 32'd6);
      check("post_rst_hi", HI, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
